// File: rtl/sprite_engine.sv
// Purpose : scaled bitmap sprite renderer for the 640x480 pixel stream; emits colour index + drawing flag per sx.
// Latency : outputs registered and aligned to the current sx (ROM fetch issued two pixels ahead, 1-cycle ROM).
// Backpress: none; free-running pixel stream, one pixel per clk, no stall input.
//
// Ports:
//   clk, rst           pixel clock, synchronous active-high reset
//   line               one-cycle pulse >= 3 clk before sx == 0; latches sprx/spry for the line
//   sx, sy             signed pixel counters (sx +1 per clk, sy stable across the line)
//   sprx, spry         signed sprite top-left corner in screen pixels
//   pix, drawing       colour index (0 when not drawing) and sprite-coverage flag for sx
//
// The bitmap is a packed parameter, row-major, pixel 0 in the least significant bits.
module sprite_engine #(
    parameter int CORDW      = 16,
    parameter int H_RES      = 640,
    parameter int SPR_WIDTH  = 8,
    parameter int SPR_HEIGHT = 8,
    parameter int SPR_SCALE  = 3,
    parameter int SPR_DATAW  = 1,
    parameter logic [SPR_WIDTH*SPR_HEIGHT*SPR_DATAW-1:0] SPR_BITMAP = 64'h0003_0303_1F03_033F
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic signed [CORDW-1:0] sprx,
    input  logic signed [CORDW-1:0] spry,
    output logic [SPR_DATAW-1:0]    pix,
    output logic                    drawing
);
    // One extra bit so that sx + 2 and sprx + sprite width never overflow.
    localparam int XW = CORDW + 1;
    localparam int AW = $clog2(SPR_WIDTH * SPR_HEIGHT);

    localparam logic signed [XW-1:0] LOOKAHEAD  = 2;
    localparam logic signed [XW-1:0] SPR_W_PX   = XW'(SPR_WIDTH << SPR_SCALE);
    localparam logic signed [XW-1:0] SPR_H_PX   = XW'(SPR_HEIGHT << SPR_SCALE);
    localparam logic signed [XW-1:0] SPR_W_LAST = XW'((SPR_WIDTH << SPR_SCALE) - 1);
    localparam logic signed [XW-1:0] H_RES_X    = XW'(H_RES);
    localparam logic signed [XW-1:0] H_LAST     = XW'(H_RES - 1);

    typedef enum logic [2:0] {
        IDLE, REG_POS, ACTIVE, WAIT_POS, SPR_LINE, WAIT_DATA
    } state_t;

    state_t                  state_q,  state_d;
    logic signed [CORDW-1:0] sprx_l_q, sprx_l_d;
    logic signed [CORDW-1:0] spry_l_q, spry_l_d;
    logic                    v_hit_q,  v_hit_d;
    logic                    fetch_q,  fetch_d;
    logic [SPR_DATAW-1:0]    rom_q,    rom_d;
    logic [SPR_DATAW-1:0]    pix_q,    pix_d;
    logic                    drawing_q, drawing_d;

    logic signed [XW-1:0] sx_x, sy_x, sprx_l_x, spry_l_x;
    logic signed [XW-1:0] xa, dx, dy;
    logic                 v_in, h_in, fetch_en, fetch_last;
    logic [AW-1:0]        row_a, col_a, addr;

    always_comb begin
        sx_x     = {sx[CORDW-1], sx};
        sy_x     = {sy[CORDW-1], sy};
        sprx_l_x = {sprx_l_q[CORDW-1], sprx_l_q};
        spry_l_x = {spry_l_q[CORDW-1], spry_l_q};

        // Fetch target is two pixels ahead: one cycle for the ROM, one for the output flop.
        xa = sx_x + LOOKAHEAD;
        dx = xa - sprx_l_x;
        dy = sy_x - spry_l_x;

        v_in = !dy[XW-1] && (dy < SPR_H_PX);
        h_in = !xa[XW-1] && (xa < H_RES_X) && !dx[XW-1] && (dx < SPR_W_PX);

        // Fetching starts right after the latch so a sprite touching sx == 0 is
        // covered even when the line pulse arrives only 3 clk ahead.
        fetch_en   = (state_q == REG_POS) || (state_q == ACTIVE) ||
                     (state_q == WAIT_POS) || (state_q == SPR_LINE);
        fetch_last = (dx == SPR_W_LAST) || (xa == H_LAST);

        // Only meaningful while v_in && h_in, where both fit in AW bits.
        row_a = AW'(dy >>> SPR_SCALE);
        col_a = AW'(dx >>> SPR_SCALE);
        addr  = row_a * AW'(SPR_WIDTH) + col_a;
    end

    always_comb begin
        state_d   = state_q;
        sprx_l_d  = sprx_l_q;
        spry_l_d  = spry_l_q;
        v_hit_d   = v_hit_q;
        fetch_d   = fetch_en && v_in && h_in;
        rom_d     = fetch_d ? SPR_BITMAP[int'(addr)*SPR_DATAW +: SPR_DATAW] : '0;
        drawing_d = fetch_q;
        pix_d     = fetch_q ? rom_q : '0;

        case (state_q)
            IDLE:      state_d = IDLE;
            REG_POS: begin
                v_hit_d = v_in;
                state_d = ACTIVE;
            end
            ACTIVE:    state_d = v_hit_q ? WAIT_POS : IDLE;
            WAIT_POS: begin
                // Covers left clip too: the first hitting fetch may be mid-sprite.
                if (fetch_d) state_d = fetch_last ? WAIT_DATA : SPR_LINE;
            end
            SPR_LINE: begin
                if (!fetch_d || fetch_last) state_d = WAIT_DATA;
            end
            WAIT_DATA: state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        // A line pulse in any state restarts with fresh coordinates.
        if (line) begin
            state_d  = REG_POS;
            sprx_l_d = sprx;
            spry_l_d = spry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sprx_l_q  <= '0;
            spry_l_q  <= '0;
            v_hit_q   <= 1'b0;
            fetch_q   <= 1'b0;
            rom_q     <= '0;
            pix_q     <= '0;
            drawing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sprx_l_q  <= sprx_l_d;
            spry_l_q  <= spry_l_d;
            v_hit_q   <= v_hit_d;
            fetch_q   <= fetch_d;
            rom_q     <= rom_d;
            pix_q     <= pix_d;
            drawing_q <= drawing_d;
        end
    end

    assign pix     = pix_q;
    assign drawing = drawing_q;

endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine: drives whole lines of sx with a line pulse
// 3 clk before sx == 0 and compares every pixel against the sprite equation,
// then checks hand-computed spans and bitmap bits for each scenario.
module tb_sprite_engine;
    // Irregular bitmap so neighbouring columns differ (row 0 in the low byte).
    localparam logic [63:0] BMP  = 64'hA5C3_0FF0_96E1_7B2D;
    localparam int          NONE = 9999;

    logic                clk = 1'b0;
    logic                rst;
    logic                line;
    logic signed [15:0]  sx, sy, sprx, spry;
    logic [0:0]          pix;
    logic                drawing;

    sprite_engine #(.SPR_BITMAP(BMP)) dut (
        .clk     (clk),
        .rst     (rst),
        .line    (line),
        .sx      (sx),
        .sy      (sy),
        .sprx    (sprx),
        .spry    (spry),
        .pix     (pix),
        .drawing (drawing)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [63:0] bmp_v  = BMP;
    int          m_sprx, m_spry;
    bit          m_valid = 1'b0;
    int          cnt, first_x, last_x;
    int          drw_a [0:659];
    int          pix_a [0:659];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_draw(input int x);
        int dx, dy;
        dx = x - m_sprx;
        dy = int'(sy) - m_spry;
        return (m_valid && x >= 0 && x < 640 && dx >= 0 && dx < 64 && dy >= 0 && dy < 64) ? 1 : 0;
    endfunction

    function automatic int exp_pix(input int x);
        int dx, dy;
        dx = x - m_sprx;
        dy = int'(sy) - m_spry;
        if (exp_draw(x) == 0) return 0;
        return int'(bmp_v[(dy / 8) * 8 + (dx / 8)]);
    endfunction

    // One full line: sx from -6 to 659, line pulse at sx == -3.
    task automatic run_line(input int px, input int py, input int y,
                            input int chg_at, input int chg_val, input int rst_at);
        int e;
        cnt = 0; first_x = -999; last_x = -999;
        sprx = 16'(px); spry = 16'(py); sy = 16'(y);
        for (int x = -6; x < 660; x++) begin
            @(posedge clk); #1;
            sx   = 16'(x);
            line = (x == -3);
            rst  = (x == rst_at);
            if (x == chg_at) sprx = 16'(chg_val);
            if (x == -3) begin
                m_sprx  = px;
                m_spry  = py;
                m_valid = 1'b1;
            end
            @(negedge clk);
            e = exp_draw(x);
            chk($sformatf("draw sx=%0d", x), int'(drawing), e);
            chk($sformatf("pix sx=%0d", x), int'(pix), exp_pix(x));
            if (x >= 0) begin
                drw_a[x] = int'(drawing);
                pix_a[x] = int'(pix);
            end
            if (drawing === 1'b1) begin
                cnt++;
                if (first_x == -999) first_x = x;
                last_x = x;
            end
            if (x == rst_at) m_valid = 1'b0;
        end
        line = 1'b0;
        rst  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; line = 1'b0; sx = '0; sy = '0; sprx = '0; spry = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset drawing", int'(drawing), 0);
        chk("reset pix", int'(pix), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Centre, row 0 = 0x2D -> cols 1,0,1,1,0,1,0,0
        run_line(296, 216, 216, NONE, 0, NONE);
        chk("t1 cnt", cnt, 64);
        chk("t1 first", first_x, 296);
        chk("t1 last", last_x, 359);
        chk("t1 pix296", pix_a[296], 1);
        chk("t1 pix303", pix_a[303], 1);
        chk("t1 pix304", pix_a[304], 0);
        chk("t1 pix312", pix_a[312], 1);
        chk("t1 drw360", drw_a[360], 0);

        // Left clip, row 1 = 0x7B: rom[10]=0, rom[11]=1
        run_line(-20, 100, 108, NONE, 0, NONE);
        chk("t2 cnt", cnt, 44);
        chk("t2 first", first_x, 0);
        chk("t2 last", last_x, 43);
        chk("t2 pix0", pix_a[0], 0);
        chk("t2 pix3", pix_a[3], 0);
        chk("t2 pix4", pix_a[4], 1);
        chk("t2 pix11", pix_a[11], 1);

        // Right clip
        run_line(600, 100, 100, NONE, 0, NONE);
        chk("t3 cnt", cnt, 40);
        chk("t3 first", first_x, 600);
        chk("t3 last", last_x, 639);
        chk("t3 drw640", drw_a[640], 0);

        // Vertical edges, row 7 = 0xA5
        run_line(296, 100, 99, NONE, 0, NONE);
        chk("t4 above cnt", cnt, 0);
        run_line(296, 100, 164, NONE, 0, NONE);
        chk("t4 below cnt", cnt, 0);
        run_line(296, 100, 163, NONE, 0, NONE);
        chk("t4 row7 cnt", cnt, 64);
        chk("t4 pix296", pix_a[296], 1);
        chk("t4 pix304", pix_a[304], 0);
        chk("t4 pix352", pix_a[352], 1);

        // Mid-line sprx change ignored until next line
        run_line(296, 216, 220, 300, 100, NONE);
        chk("t5 cnt", cnt, 64);
        chk("t5 first", first_x, 296);
        run_line(100, 216, 220, NONE, 0, NONE);
        chk("t5 next first", first_x, 100);
        chk("t5 next last", last_x, 163);

        // Reset inside the sprite, then a normal line
        run_line(296, 216, 216, NONE, 0, 320);
        chk("t6 cnt", cnt, 25);
        chk("t6 last", last_x, 320);
        chk("t6 drw321", drw_a[321], 0);
        chk("t6 pix321", pix_a[321], 0);
        run_line(296, 216, 216, NONE, 0, NONE);
        chk("t6 after cnt", cnt, 64);

        // Reset coinciding with the line pulse wins
        run_line(296, 216, 216, NONE, 0, -3);
        chk("t7 rst+line cnt", cnt, 0);

        // Single-pixel slivers and fully off-screen sprites
        run_line(-63, 216, 216, NONE, 0, NONE);
        chk("t8 sliver left cnt", cnt, 1);
        chk("t8 sliver left first", first_x, 0);
        run_line(639, 216, 216, NONE, 0, NONE);
        chk("t8 sliver right cnt", cnt, 1);
        chk("t8 sliver right first", first_x, 639);
        run_line(-64, 216, 216, NONE, 0, NONE);
        chk("t8 off left cnt", cnt, 0);
        run_line(640, 216, 216, NONE, 0, NONE);
        chk("t8 off right cnt", cnt, 0);
        run_line(296, -200, 216, NONE, 0, NONE);
        chk("t8 off above cnt", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
